adc_emu: RTL
============

ADC_EMU -- requirements
Module: adc_emu

Interface
REQ-001 Parameter CONV_PERIOD, default 1024: clk cycles between conversion ticks; legal range 300..65535.
REQ-002 Parameter DRDY_WIDTH, default 4: clk cycles nDRDY is held low per frame; legal range 1..CONV_PERIOD/4.
REQ-003 Parameter FRAME_TIMEOUT, default 512: maximum clk cycles per frame before abort.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 data_in  input  16  next sample word to transmit.
REQ-007 load  input  1  write strobe for data_in; accepted only when ready=1.
REQ-008 ready  output  1  holding register empty.
REQ-009 SCLK  input  1  serial clock from the ADC reader; asynchronous to clk.
REQ-010 nCS  input  1  chip select from the reader, active-low.
REQ-011 SDOUT  output  1  serial data to the reader's SDIN, MSB first.
REQ-012 nDRDY  output  1  data-ready strobe to the reader, active-low.
REQ-013 busy  output  1  frame in progress.
REQ-014 underrun  output  1  one-cycle pulse: tick with empty holding register.
REQ-015 missed  output  1  one-cycle pulse: tick arrived while busy, tick dropped.
REQ-016 timeout  output  1  one-cycle pulse: frame aborted by FRAME_TIMEOUT.

Function
REQ-017 Period counter SHALL count 0..CONV_PERIOD-1 and wrap; it SHALL assert tick for one cycle on wrap.
REQ-018 load=1 with ready=1 SHALL capture data_in into the holding register and drive ready=0 next cycle; load with ready=0 SHALL be ignored.
REQ-019 SCLK and nCS SHALL each pass through a 2-flop synchronizer, with rising/falling edge detect on a third flop.
REQ-020 FSM states: IDLE, FRAME.
REQ-021 IDLE + tick: copy holding register to the shift register (or keep the previous word if the holding register is empty and pulse underrun), set ready=1, enter FRAME, drive SDOUT = bit 15 on the next cycle.
REQ-022 FRAME: nDRDY SHALL be 0 for exactly the first DRDY_WIDTH cycles, then 1.
REQ-023 FRAME: each synchronized SCLK rising edge SHALL increment a 5-bit bit counter (0..16).
REQ-024 FRAME: each synchronized SCLK falling edge with bit count below 16 SHALL shift left and present the next bit on SDOUT.
REQ-025 FRAME: bit count reaching 16 SHALL return to IDLE, drive SDOUT=0 and busy=0, and hold nDRDY=1.
REQ-026 SCLK edges SHALL count in FRAME even while nDRDY is still 0; SCLK edges in IDLE SHALL be ignored.
REQ-027 Synchronized nCS=1 in FRAME SHALL abort to IDLE with no error pulse; the word is lost.
REQ-028 A frame counter reaching FRAME_TIMEOUT SHALL abort to IDLE and pulse timeout.
REQ-029 A tick in FRAME SHALL be dropped and pulse missed; frame progress SHALL be unaffected.
REQ-030 Same-cycle tick and load in IDLE with an empty holding register: the frame SHALL transmit the previous word and pulse underrun; data_in SHALL be captured into the holding register, so ready=0 next cycle.
REQ-031 busy=1 exactly while in FRAME.

Reset
REQ-032 Reset=0 SHALL immediately force IDLE, nDRDY=1, SDOUT=0, busy=0, ready=1, and underrun/missed/timeout=0.
REQ-033 Reset SHALL also clear all counters, synchronizers, the holding register and the shift register to 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release, the first tick occurs CONV_PERIOD cycles later.

Verification
REQ-035 Load 0xA5C3, drive a 16-pulse SCLK (period 8 clk) after nDRDY falls -> the bench SHALL see MSB-first sampling on SCLK rises equal to 0xA5C3, nDRDY low for 4 cycles, then busy=0.
REQ-036 No load before the second tick -> underrun pulses once and 0xA5C3 is retransmitted.
REQ-037 Load 0x0001 while ready=0 -> ignored; the transmitted word remains the earlier one.
REQ-038 Only 8 SCLK pulses in a frame -> timeout pulses 512 cycles after frame start, and the next frame transmits correctly.
REQ-039 CONV_PERIOD=300 with FRAME_TIMEOUT=512 and SCLK withheld -> missed pulses at the tick inside the frame.
REQ-040 Reset=0 at bit 7 of a frame -> all outputs at reset values in the same cycle; normal operation resumes after the first tick.

Source files
------------

// File: rtl/adc_emu.sv
// adc_emu: emulates a serial ADC. A free-running period counter produces
// conversion ticks; each tick launches a 16-bit frame that an external reader
// clocks out MSB-first with its own SCLK. nDRDY is strobed low for the first
// few cycles of each frame.
module adc_emu #(
   parameter int CONV_PERIOD   = 1024,
   parameter int DRDY_WIDTH    = 4,
   parameter int FRAME_TIMEOUT = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        load,
   output logic        ready,
   input  logic        SCLK,
   input  logic        nCS,
   output logic        SDOUT,
   output logic        nDRDY,
   output logic        busy,
   output logic        underrun,
   output logic        missed,
   output logic        timeout
);

   typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

   localparam logic [15:0] PER_LAST = 16'(CONV_PERIOD - 1);
   localparam logic [15:0] DRDY_W   = 16'(DRDY_WIDTH);
   localparam logic [15:0] TO_LAST  = 16'(FRAME_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_per_cnt;
   logic        r_tick;
   logic [2:0]  r_sclk_s;
   logic [1:0]  r_ncs_s;
   logic [15:0] r_hold;
   logic        r_ready;
   logic [15:0] r_shift;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_frm_cnt;
   logic        r_underrun;
   logic        r_missed;
   logic        r_timeout;

   logic        w_sclk_rise;
   logic        w_sclk_fall;
   logic        w_ncs_hi;
   logic        w_in_frame;
   logic        w_idle_tick;
   logic        w_done;
   logic        w_to;
   logic        w_to_evt;

   assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
   assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
   // Only the level of nCS matters (abort while deselected), so no edge flop.
   assign w_ncs_hi    = r_ncs_s[1];
   assign w_in_frame  = (r_state == FRAME);
   assign w_idle_tick = (r_state == IDLE) && r_tick;
   assign w_done      = (r_bit_cnt == 5'd16);
   assign w_to        = (r_frm_cnt == TO_LAST);
   // Completion and deselect take priority; only a genuine stall reports timeout.
   assign w_to_evt    = w_in_frame && !w_done && !w_ncs_hi && w_to;

   // Conversion period counter; tick is registered so it is high while the count reads 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_per_cnt <= 16'd0;
         r_tick    <= 1'b0;
      end else if (r_per_cnt == PER_LAST) begin
         r_per_cnt <= 16'd0;
         r_tick    <= 1'b1;
      end else begin
         r_per_cnt <= r_per_cnt + 16'd1;
         r_tick    <= 1'b0;
      end
   end

   // Synchronize reader-side SCLK (with edge-detect flop) and nCS into clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sclk_s <= 3'b000;
         r_ncs_s  <= 2'b00;
      end else begin
         r_sclk_s <= {r_sclk_s[1:0], SCLK};
         r_ncs_s  <= {r_ncs_s[0], nCS};
      end
   end

   // Frame state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: ticks start frames; done, deselect or timeout end them.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (r_tick) w_state_nxt = FRAME;
         FRAME:   if (w_done || w_ncs_hi || w_to) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Holding register: a load while empty wins over the tick that empties it.
   // The held word is left in place when consumed, so an underrun resends it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold  <= 16'd0;
         r_ready <= 1'b1;
      end else if (load && r_ready) begin
         r_hold  <= data_in;
         r_ready <= 1'b0;
      end else if (w_idle_tick) begin
         r_ready <= 1'b1;
      end
   end

   // Shift register, bit counter and frame-age counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift   <= 16'd0;
         r_bit_cnt <= 5'd0;
         r_frm_cnt <= 16'd0;
      end else if (w_idle_tick) begin
         r_shift   <= r_hold;
         r_bit_cnt <= 5'd0;
         r_frm_cnt <= 16'd0;
      end else if (w_in_frame) begin
         r_frm_cnt <= r_frm_cnt + 16'd1;
         if (w_sclk_rise && r_bit_cnt < 5'd16) r_bit_cnt <= r_bit_cnt + 5'd1;
         if (w_sclk_fall && r_bit_cnt < 5'd16) r_shift <= {r_shift[14:0], 1'b0};
      end
   end

   // One-cycle status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_underrun <= 1'b0;
         r_missed   <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_underrun <= w_idle_tick && r_ready;
         r_missed   <= w_in_frame && r_tick;
         r_timeout  <= w_to_evt;
      end
   end

   assign ready    = r_ready;
   assign busy     = w_in_frame;
   assign SDOUT    = w_in_frame & r_shift[15];
   assign nDRDY    = !(w_in_frame && (r_frm_cnt < DRDY_W));
   assign underrun = r_underrun;
   assign missed   = r_missed;
   assign timeout  = r_timeout;

endmodule
